ram_mux_arbiter: RTL
====================

RAM_MUX_ARBITER -- requirements
Module: ram_mux_arbiter

Interface
REQ-001 Parameter SLOT_LEN, default 2, SHALL set the cycles per time slot; legal range 2..8.
REQ-002 Parameter DW, default 8, SHALL set the RAM data width.
REQ-003 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 RST  input  1  SHALL be a synchronous, active-high reset, sampled on the CLK rising edge.
REQ-005 CPU_REQ  input  1  SHALL be the CPU access request, held until CPU_ACK.
REQ-006 CPU_WR  input  1  SHALL mark the request as a write (1) or a read (0), sampled with CPU_REQ.
REQ-007 CPU_WDATA  input  DW  SHALL be the write data, sampled at slot start.
REQ-008 VID_BLANK  input  1  SHALL be high during video blanking.
REQ-009 RAM_DIN  input  DW  SHALL be the data read back from the shared RAM.
REQ-010 G  output  1  SHALL be the address-mux enable; 0 forces mux outputs to 0.
REQ-011 SELA  output  1  SHALL be the mux select: 1 = CPU address (A side), 0 = video address (B side).
REQ-012 RAM_WE  output  1  SHALL be the active-high RAM write strobe.
REQ-013 RAM_DOUT  output  DW  SHALL be the latched CPU write data driven to the RAM.
REQ-014 CPU_ACK  output  1  SHALL be a one-cycle completion pulse.
REQ-015 CPU_RDATA  output  DW  SHALL be the CPU read data; valid from CPU_ACK until the next CPU_ACK.
REQ-016 VID_VALID  output  1  SHALL be a one-cycle pulse when VID_DATA updates.
REQ-017 VID_DATA  output  DW  SHALL be the latched video read data.

Function
REQ-018 A slot counter SHALL count 0..SLOT_LEN-1 and wrap; at wrap, the slot type SHALL alternate S_VID -> S_CPU -> S_VID.
REQ-019 In an S_VID slot: G=1, SELA=0, RAM_WE=0. On the last slot cycle, VID_DATA<=RAM_DIN and VID_VALID=1.
REQ-020 At the first cycle of an S_CPU slot, CPU_REQ SHALL be sampled. If high, the slot becomes an access: G=1 and SELA=1 for the whole slot, and CPU_WR/CPU_WDATA are latched.
REQ-021 In an S_CPU slot with no request sampled: G=0, SELA=0, RAM_WE=0, and no CPU_ACK.
REQ-022 Write access: RAM_WE=1 on the last slot cycle only; RAM_DOUT holds the latched data for the whole slot.
REQ-023 Read access: CPU_RDATA<=RAM_DIN on the last slot cycle.
REQ-024 Either access SHALL pulse CPU_ACK on the last slot cycle. Latency from slot start to ACK = SLOT_LEN cycles.
REQ-025 A CPU_REQ rising mid-slot SHALL wait for the next CPU slot start. Worst-case wait = 2*SLOT_LEN-1 cycles before the sampling edge.
REQ-026 If CPU_REQ drops mid-access, the access SHALL still complete, including the ACK and any write.
REQ-027 CPU_REQ still high in the cycle after CPU_ACK SHALL be treated as a new request at the next eligible slot.
REQ-028 SELA and G SHALL change only at slot boundaries, so the mux never switches mid-access.
REQ-029 Video slots SHALL never be skipped or delayed by CPU traffic, except as allowed by REQ-034.

Reset
REQ-030 While RST=1, outputs SHALL be: G=0, SELA=0, RAM_WE=0, CPU_ACK=0, VID_VALID=0, RAM_DOUT=0, CPU_RDATA=0, VID_DATA=0.
REQ-031 While RST=1, the slot counter SHALL be 0 and the slot type S_VID.
REQ-032 The first cycle after RST falls SHALL be cycle 0 of an S_VID slot.
REQ-033 RST asserted mid-access SHALL abort the access: no ACK is issued and RAM_WE is forced to 0 in the reset cycle.

Configuration
REQ-034 When macro RAM_ARB_BLANK_STEAL_EN is defined: at the start of an S_VID slot with VID_BLANK=1 and CPU_REQ=1, the slot SHALL be served as a CPU access per REQ-020..024, and VID_VALID SHALL not pulse in that slot.
REQ-035 When RAM_ARB_BLANK_STEAL_EN is undefined, VID_BLANK SHALL be ignored and video slots are always served.

Verification
REQ-036 Reset release, SLOT_LEN=2, no requests -> G=1/SELA=0 for 2 cycles, then G=0 for 2, repeating; VID_VALID pulses every 4 cycles.
REQ-037 CPU_REQ=1, CPU_WR=1, CPU_WDATA=0xA5 raised at cycle 1 -> SELA=1 in cycles 2-3, RAM_WE=1 and CPU_ACK=1 in cycle 3 only, RAM_DOUT=0xA5.
REQ-038 Read with RAM_DIN=0x3C in a CPU slot -> CPU_RDATA=0x3C with the CPU_ACK pulse; the following video slot still pulses VID_VALID.
REQ-039 CPU_REQ dropped at access cycle 0 -> ACK still occurs at the slot end; RST asserted mid-write -> RAM_WE=0 and no ACK.
REQ-040 RAM_ARB_BLANK_STEAL_EN defined, VID_BLANK=1, CPU_REQ pending at video slot start -> access served in the video slot, no VID_VALID; with the macro undefined -> access waits for the CPU slot.

Source files
------------

// File: rtl/ram_mux_arbiter.sv
// Time-slot arbiter sharing one RAM between video refresh and CPU accesses.
// Optional macro RAM_ARB_BLANK_STEAL_EN lets a pending CPU access take a video slot during blanking.
module ram_mux_arbiter #(
   parameter int SLOT_LEN = 2,
   parameter int DW       = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_wr,
   input  logic [DW-1:0] cpu_wdata,
   input  logic          vid_blank,
   input  logic [DW-1:0] ram_din,
   output logic          g,
   output logic          sela,
   output logic          ram_we,
   output logic [DW-1:0] ram_dout,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   output logic          vid_valid,
   output logic [DW-1:0] vid_data
);
   localparam int CW = (SLOT_LEN > 32'sd2) ? $clog2(SLOT_LEN) : 32'sd1;
   localparam logic [CW-1:0] LAST = CW'(SLOT_LEN - 32'sd1);

   typedef enum logic {S_VID = 1'b0, S_CPU = 1'b1} slot_t;

   logic [CW-1:0] cnt_r, cnt_nxt_s;
   slot_t         slot_r, slot_nxt_s;
   logic          run_r;
   logic          acc_r, acc_nxt_s;
   logic          wr_r, wr_nxt_s;
   logic          start_s, req_s, steal_s, last_nxt_s;
   logic          g_r, sela_r, ram_we_r, cpu_ack_r, vid_valid_r;
   logic          g_nxt_s, sela_nxt_s, we_nxt_s, ack_nxt_s, vv_nxt_s;
   logic [DW-1:0] ram_dout_r, cpu_rdata_r, vid_data_r;

   // A request still high during its own ACK cycle belongs to the finished access
   assign req_s = cpu_req & ~cpu_ack_r;

`ifdef RAM_ARB_BLANK_STEAL_EN
   assign steal_s = vid_blank & req_s;
`else
   logic unused_s;
   assign unused_s = vid_blank;
   assign steal_s  = 1'b0;
`endif

   // Slot sequencing; the access decision is taken only at slot boundaries
   always_comb begin
      cnt_nxt_s  = cnt_r;
      slot_nxt_s = slot_r;
      acc_nxt_s  = acc_r;
      wr_nxt_s   = wr_r;
      start_s    = 1'b0;
      if (!run_r) begin
         cnt_nxt_s  = {CW{1'b0}};
         slot_nxt_s = S_VID;
         start_s    = steal_s;
         acc_nxt_s  = steal_s;
         wr_nxt_s   = steal_s & cpu_wr;
      end else if (cnt_r == LAST) begin
         cnt_nxt_s = {CW{1'b0}};
         case (slot_r)
            S_VID: begin
               slot_nxt_s = S_CPU;
               start_s    = req_s;
            end
            S_CPU: begin
               slot_nxt_s = S_VID;
               start_s    = steal_s;
            end
            default: begin
               slot_nxt_s = S_VID;
               start_s    = 1'b0;
            end
         endcase
         acc_nxt_s = start_s;
         wr_nxt_s  = start_s ? cpu_wr : wr_r;
      end else begin
         cnt_nxt_s = cnt_r + CW'(1'b1);
      end
   end

   // Next values of the registered mux controls and strobes
   always_comb begin
      last_nxt_s = (cnt_nxt_s == LAST);
      g_nxt_s    = (slot_nxt_s == S_VID) | acc_nxt_s;
      sela_nxt_s = acc_nxt_s;
      we_nxt_s   = acc_nxt_s & wr_nxt_s & last_nxt_s;
      ack_nxt_s  = acc_nxt_s & last_nxt_s;
      vv_nxt_s   = (slot_nxt_s == S_VID) & ~acc_nxt_s & last_nxt_s;
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r       <= {CW{1'b0}};
         slot_r      <= S_VID;
         run_r       <= 1'b0;
         acc_r       <= 1'b0;
         wr_r        <= 1'b0;
         g_r         <= 1'b0;
         sela_r      <= 1'b0;
         ram_we_r    <= 1'b0;
         cpu_ack_r   <= 1'b0;
         vid_valid_r <= 1'b0;
         ram_dout_r  <= {DW{1'b0}};
         cpu_rdata_r <= {DW{1'b0}};
         vid_data_r  <= {DW{1'b0}};
      end else begin
         cnt_r       <= cnt_nxt_s;
         slot_r      <= slot_nxt_s;
         run_r       <= 1'b1;
         acc_r       <= acc_nxt_s;
         wr_r        <= wr_nxt_s;
         g_r         <= g_nxt_s;
         sela_r      <= sela_nxt_s;
         ram_we_r    <= we_nxt_s;
         cpu_ack_r   <= ack_nxt_s;
         vid_valid_r <= vv_nxt_s;
         if (start_s) begin
            ram_dout_r <= cpu_wdata;
         end
         if (ack_nxt_s && !wr_nxt_s) begin
            cpu_rdata_r <= ram_din;
         end
         if (vv_nxt_s) begin
            vid_data_r <= ram_din;
         end
      end
   end

   assign g         = g_r;
   assign sela      = sela_r;
   assign ram_we    = ram_we_r;
   assign ram_dout  = ram_dout_r;
   assign cpu_ack   = cpu_ack_r;
   assign cpu_rdata = cpu_rdata_r;
   assign vid_valid = vid_valid_r;
   assign vid_data  = vid_data_r;

endmodule
